// File: rtl/gmii_rx_video.sv
// GMII receive parser for the HDMI-over-UDP video link: strips framing/headers, emits {Y,C} words, checks FCS.
// Optional build macro MAC_FILTER_EN: accept only frames addressed to LOCAL_MAC.
module gmii_rx_video #(
    parameter logic [47:0] LOCAL_MAC    = 48'h002345678902,
    parameter logic [15:0] ETH_TYPE     = 16'h0800,
    parameter logic [15:0] UDP_DST_PORT = 16'h3039,
    parameter int          PIX_BYTES    = 1280
) (
    input  logic        rx_clk,
    input  logic        sys_rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        pix_we,
    output logic [15:0] pix_data,
    output logic        line_start,
    output logic [11:0] line_y,
    output logic [3:0]  line_x,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt
);

    localparam int          PCW         = $clog2(PIX_BYTES);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        S_WAIT_IDLE, S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR,
        S_LINE_HDR, S_PAYLOAD, S_FCS, S_FCS_END, S_ERR_WAIT, S_DROP
    } state_t;

    state_t           state;
    state_t           hdr_nxt;
    logic [4:0]       hdr_cnt;
    logic [PCW-1:0]   pay_cnt;
    logic [7:0]       hdr_lo;
    logic [7:0]       y_byte;
    logic [31:0]      crc;
    logic             hdr_bad;
    logic             hdr_end;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reflected CRC-32, one bit per step, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 8; b++)
            c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [4:0] idx);
        logic [47:0] sh;
        sh = LOCAL_MAC >> (8 * (5 - int'(idx)));
        return sh[7:0];
    endfunction

    always_comb begin
        hdr_bad = 1'b0;
        hdr_end = 1'b0;
        hdr_nxt = S_IDLE;
        case (state)
            S_ETH_HDR: begin
                if (hdr_cnt == 5'd12 && rxd != ETH_TYPE[15:8]) hdr_bad = 1'b1;
                if (hdr_cnt == 5'd13 && rxd != ETH_TYPE[7:0])  hdr_bad = 1'b1;
`ifdef MAC_FILTER_EN
                if (hdr_cnt < 5'd6 && rxd != mac_byte(hdr_cnt)) hdr_bad = 1'b1;
`endif
                hdr_end = (hdr_cnt == 5'd13);
                hdr_nxt = S_IP_HDR;
            end
            S_IP_HDR: begin
                if (hdr_cnt == 5'd0 && rxd != 8'h45) hdr_bad = 1'b1;
                if (hdr_cnt == 5'd9 && rxd != 8'h11) hdr_bad = 1'b1;
                hdr_end = (hdr_cnt == 5'd19);
                hdr_nxt = S_UDP_HDR;
            end
            S_UDP_HDR: begin
                if (hdr_cnt == 5'd2 && rxd != UDP_DST_PORT[15:8]) hdr_bad = 1'b1;
                if (hdr_cnt == 5'd3 && rxd != UDP_DST_PORT[7:0])  hdr_bad = 1'b1;
                hdr_end = (hdr_cnt == 5'd7);
                hdr_nxt = S_LINE_HDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_WAIT_IDLE;
            hdr_cnt    <= '0;
            pay_cnt    <= '0;
            pix_we     <= 1'b0;
            pix_data   <= '0;
            line_start <= 1'b0;
            line_y     <= '0;
            line_x     <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            pix_we     <= 1'b0;
            line_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_WAIT_IDLE: if (!rx_dv) state <= S_IDLE;
                S_IDLE, S_PREAMBLE: begin
                    if (!rx_dv) begin
                        if (state == S_PREAMBLE) drop_cnt <= sat_inc(drop_cnt);
                        state <= S_IDLE;
                    end else if (!rx_er && rxd == 8'h55) begin
                        state <= S_PREAMBLE;
                    end else if (!rx_er && rxd == 8'hD5) begin
                        state   <= S_ETH_HDR;
                        hdr_cnt <= '0;
                    end else begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_DROP;
                    end
                end
                S_ETH_HDR, S_IP_HDR, S_UDP_HDR: begin
                    if (!rx_dv) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_IDLE;
                    end else if (rx_er || hdr_bad) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_DROP;
                    end else if (hdr_end) begin
                        state   <= hdr_nxt;
                        hdr_cnt <= '0;
                    end else begin
                        hdr_cnt <= hdr_cnt + 5'd1;
                    end
                end
                // From here on a started line must be closed with frame_done.
                S_LINE_HDR, S_PAYLOAD, S_FCS: begin
                    if (!rx_dv) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        err_cnt    <= sat_inc(err_cnt);
                        state      <= S_IDLE;
                    end else if (rx_er) begin
                        state <= S_ERR_WAIT;
                    end else if (state == S_LINE_HDR) begin
                        if (hdr_cnt == 5'd0) begin
                            hdr_cnt <= 5'd1;
                        end else begin
                            line_y     <= {rxd[3:0], hdr_lo};
                            line_x     <= rxd[7:4];
                            line_start <= 1'b1;
                            pay_cnt    <= '0;
                            state      <= S_PAYLOAD;
                        end
                    end else if (state == S_PAYLOAD) begin
                        if (pay_cnt[0]) begin
                            pix_data <= {y_byte, rxd};
                            pix_we   <= 1'b1;
                        end
                        if (pay_cnt == PCW'(PIX_BYTES - 1)) begin
                            hdr_cnt <= '0;
                            state   <= S_FCS;
                        end else begin
                            pay_cnt <= pay_cnt + 1'b1;
                        end
                    end else if (hdr_cnt == 5'd3) begin
                        state <= S_FCS_END;
                    end else begin
                        hdr_cnt <= hdr_cnt + 5'd1;
                    end
                end
                S_FCS_END: begin
                    if (!rx_dv) begin
                        frame_done <= 1'b1;
                        frame_ok   <= (crc == CRC_RESIDUE);
                        if (crc != CRC_RESIDUE) err_cnt <= sat_inc(err_cnt);
                        state <= S_IDLE;
                    end else begin
                        state <= S_ERR_WAIT;
                    end
                end
                S_ERR_WAIT: begin
                    if (!rx_dv) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        err_cnt    <= sat_inc(err_cnt);
                        state      <= S_IDLE;
                    end
                end
                S_DROP: if (!rx_dv) state <= S_IDLE;
                default: state <= S_WAIT_IDLE;
            endcase
        end
    end

    // Datapath scratch registers; only meaningful while the FSM is in the owning state.
    always_ff @(posedge rx_clk) begin
        if (rx_dv) begin
            if (state == S_LINE_HDR && hdr_cnt == 5'd0) hdr_lo <= rxd;
            if (state == S_PAYLOAD && !pay_cnt[0])      y_byte <= rxd;
            if (state == S_IDLE || state == S_PREAMBLE)
                crc <= 32'hFFFFFFFF;
            else if (state inside {S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_LINE_HDR, S_PAYLOAD, S_FCS})
                crc <= crc32_byte(crc, rxd);
        end
    end

endmodule

// File: tb/tb_gmii_rx_video.sv
// Directed-sequence bench for gmii_rx_video with randomized frame contents and a frame-level model.
module tb_gmii_rx_video;

    localparam logic [47:0] MAC = 48'h002345678902;

    logic        clk = 1'b0;
    logic        sys_rst_n, rx_dv, rx_er;
    logic [7:0]  rxd;
    logic        pix_we, line_start, frame_done, frame_ok;
    logic [15:0] pix_data, err_cnt, drop_cnt;
    logic [11:0] line_y;
    logic [3:0]  line_x;

    gmii_rx_video dut (
        .rx_clk(clk), .sys_rst_n(sys_rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .pix_we(pix_we), .pix_data(pix_data), .line_start(line_start),
        .line_y(line_y), .line_x(line_x), .frame_done(frame_done),
        .frame_ok(frame_ok), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #4 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic [7:0]  frm[$];
    logic [15:0] exp_pix[$];
    int          pay_off;
    int          exp_err = 0;
    int          exp_drop = 0;

    logic [15:0] obs_pix[$];
    logic [15:0] obs_ls[$];
    logic        obs_done[$];
    int          m_pix, m_ls, m_done;

    always @(negedge clk) begin
        if (pix_we)     obs_pix.push_back(pix_data);
        if (line_start) obs_ls.push_back({line_x, line_y});
        if (frame_done) obs_done.push_back(frame_ok);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pix_we"},     32'(pix_we), 0);
        chk({tag, "_pix_data"},   32'(pix_data), 0);
        chk({tag, "_line_start"}, 32'(line_start), 0);
        chk({tag, "_line_yx"},    32'({line_x, line_y}), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_frame_ok"},   32'(frame_ok), 0);
        chk({tag, "_err_cnt"},    32'(err_cnt), 0);
        chk({tag, "_drop_cnt"},   32'(drop_cnt), 0);
    endtask

    // Frame image as transmitted by gmii_tx: preamble, headers, line header, payload, FCS.
    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [11:0] ly, input logic [3:0] lx, input bit rnd);
        logic [7:0]  y, c;
        logic [31:0] crc;
        frm.delete();
        exp_pix.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int k = 0; k < 6; k++) frm.push_back(dmac[47-8*k -: 8]);
        repeat (6) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(8'h05); frm.push_back(8'h1E);
        repeat (2) frm.push_back(8'($urandom));
        frm.push_back(8'h40); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h11);
        repeat (10) frm.push_back(8'($urandom));
        repeat (2) frm.push_back(8'($urandom));
        frm.push_back(8'h30); frm.push_back(8'h39); frm.push_back(8'h05); frm.push_back(8'h0A);
        frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(ly[7:0]); frm.push_back({lx, ly[11:8]});
        pay_off = frm.size();
        for (int i = 0; i < 640; i++) begin
            y = rnd ? 8'($urandom) : 8'(i);
            c = rnd ? 8'($urandom) : ~8'(i);
            frm.push_back(y); frm.push_back(c);
            exp_pix.push_back({y, c});
        end
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < frm.size(); i++) begin
            crc = crc ^ 32'(frm[i]);
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) frm.push_back(crc[8*k +: 8]);
    endtask

    task automatic send(input int len, input int rst_at, input int er_at);
        m_pix = obs_pix.size(); m_ls = obs_ls.size(); m_done = obs_done.size();
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            rx_dv = 1'b1;
            rxd   = frm[i];
            rx_er = (i == er_at);
            if (i == rst_at) begin
                sys_rst_n = 1'b0;
                #1;
                chk_zero_outputs("rst_mid");
                exp_err = 0; exp_drop = 0;
            end
            if (rst_at >= 0 && i == rst_at + 4) begin
                sys_rst_n = 1'b1;
                m_pix = obs_pix.size(); m_ls = obs_ls.size(); m_done = obs_done.size();
            end
        end
        @(posedge clk); #1;
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        repeat (12 + $urandom_range(0, 8)) @(posedge clk);
        #2;
    endtask

    task automatic check_frame(input string tag, input int exp_words, input int exp_ls,
                               input int exp_done, input bit exp_ok,
                               input logic [11:0] ly, input logic [3:0] lx);
        int words, bad;
        words = obs_pix.size() - m_pix;
        chk({tag, "_words"}, 32'(words), 32'(exp_words));
        bad = 0;
        for (int i = 0; i < words && i < exp_words; i++)
            if (obs_pix[m_pix + i] !== exp_pix[i]) bad++;
        chk({tag, "_pix_bad"}, 32'(bad), 0);
        chk({tag, "_ls_cnt"}, 32'(obs_ls.size() - m_ls), 32'(exp_ls));
        if (exp_ls > 0 && obs_ls.size() > m_ls)
            chk({tag, "_ls_val"}, 32'(obs_ls[m_ls]), 32'({lx, ly}));
        chk({tag, "_done_cnt"}, 32'(obs_done.size() - m_done), 32'(exp_done));
        if (exp_done > 0 && obs_done.size() > m_done)
            chk({tag, "_frame_ok"}, 32'(obs_done[m_done]), 32'(exp_ok));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic good_frame(input string tag);
        logic [11:0] ly;
        logic [3:0]  lx;
        ly = 12'($urandom); lx = 4'($urandom);
        build(MAC, 16'h0800, ly, lx, 1'b1);
        send(frm.size(), -1, -1);
        check_frame(tag, 640, 1, 1, 1'b1, ly, lx);
    endtask

    initial begin
        sys_rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        sys_rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // T1 good frame with the reference pixel pattern
        build(MAC, 16'h0800, 12'h2CF, 4'h3, 1'b0);
        send(frm.size(), -1, -1);
        check_frame("t1", 640, 1, 1, 1'b1, 12'h2CF, 4'h3);
        if (obs_pix.size() >= m_pix + 640) begin
            chk("t1_first", 32'(obs_pix[m_pix]), 32'h00FF);
            chk("t1_last", 32'(obs_pix[m_pix + 639]), 32'h7F80);
        end

        // T2 payload byte 500 corrupted after FCS was computed
        build(MAC, 16'h0800, 12'h2CF, 4'h3, 1'b0);
        frm[pay_off + 500] = ~frm[pay_off + 500];
        exp_pix[250][15:8] = ~exp_pix[250][15:8];
        exp_err++;
        send(frm.size(), -1, -1);
        check_frame("t2", 640, 1, 1, 1'b0, 12'h2CF, 4'h3);

        // T3 wrong EtherType, then a good frame
        build(MAC, 16'h0806, 12'h001, 4'h0, 1'b1);
        exp_drop++;
        send(frm.size(), -1, -1);
        check_frame("t3", 0, 0, 0, 1'b0, 12'h0, 4'h0);
        good_frame("t3_next");

        // T4 truncated after 100 payload bytes, then a good frame
        build(MAC, 16'h0800, 12'h123, 4'h7, 1'b1);
        exp_err++;
        send(pay_off + 100, -1, -1);
        check_frame("t4", 50, 1, 1, 1'b0, 12'h123, 4'h7);
        good_frame("t4_next");

        // rx_er inside the FCS bytes
        build(MAC, 16'h0800, 12'hABC, 4'h5, 1'b1);
        exp_err++;
        send(frm.size(), -1, frm.size() - 2);
        check_frame("rxer_fcs", 640, 1, 1, 1'b0, 12'hABC, 4'h5);

        // One byte too many after the FCS
        build(MAC, 16'h0800, 12'h456, 4'h9, 1'b1);
        frm.push_back(8'($urandom));
        exp_err++;
        send(frm.size(), -1, -1);
        check_frame("too_long", 640, 1, 1, 1'b0, 12'h456, 4'h9);

        // rx_er inside the Ethernet header
        build(MAC, 16'h0800, 12'h777, 4'h1, 1'b1);
        exp_drop++;
        send(frm.size(), -1, 20);
        check_frame("rxer_hdr", 0, 0, 0, 1'b0, 12'h0, 4'h0);

        // T5 reset in the middle of the payload, released while rx_dv is high
        build(MAC, 16'h0800, 12'h321, 4'h2, 1'b1);
        send(frm.size(), pay_off + 300, -1);
        check_frame("t5", 0, 0, 0, 1'b0, 12'h0, 4'h0);
        chk("t5_frame_ok", 32'(frame_ok), 0);
        good_frame("t5_next");

        // T6 destination MAC differs in the last byte
        build(48'h002345678903, 16'h0800, 12'h0F0, 4'hE, 1'b1);
`ifdef MAC_FILTER_EN
        exp_drop++;
        send(frm.size(), -1, -1);
        check_frame("t6", 0, 0, 0, 1'b0, 12'h0, 4'h0);
`else
        send(frm.size(), -1, -1);
        check_frame("t6", 640, 1, 1, 1'b1, 12'h0F0, 4'hE);
`endif

        good_frame("rand_a");
        good_frame("rand_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
